// File: rtl/encode_pkg.sv
// encode_pkg: shared widths, fixed-point accumulator type and reciprocal helper for encode_interp
package encode_pkg;
  localparam int ENCODE_WID = 32;
  localparam int EXTEND_WIDTH = 20;
  localparam int MASK = 18;
  localparam int PROD_WID = ENCODE_WID + 40;
  typedef logic signed [ENCODE_WID+EXTEND_WIDTH-1:0] acc_t;
  function automatic logic [63:0] calc_recip(input int unit, input int dot, input int gap, input int ext);
    logic [63:0] n;
    n = 64'(unit * dot / gap);
    return ((64'd1 << (ext + 16)) + (n >> 1)) / n;
  endfunction
endpackage

// File: rtl/encode_axis_interp.sv
// encode_axis_interp: one axis of coarse-to-fine interpolation (delta, pipelined step multiply, accumulator)
module encode_axis_interp
  import encode_pkg::*;
#(
  parameter int WRAP_WID = 0,
  parameter int FIRST_DELTA = 0,
  parameter logic [63:0] RECIP = 64'd0,
  localparam int IW = WRAP_WID > 0 ? WRAP_WID : ENCODE_WID
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  snap,
  input  logic                  tick,
  input  logic [ENCODE_WID-1:0] sample,
  output logic [IW-1:0]         pos,
  output logic                  wrap
);
  localparam int AW = IW + EXTEND_WIDTH;
  localparam logic signed [PROD_WID-1:0] PROD0 = PROD_WID'(FIRST_DELTA) * PROD_WID'(RECIP);
  logic [ENCODE_WID-1:0] prev;
  logic signed [ENCODE_WID-1:0] delta;
  logic signed [PROD_WID-1:0] prod;
  acc_t step;
  logic [AW-1:0] acc;
  logic [AW:0] sum;
  logic signed [IW-1:0] dn, ds;
  logic [IW-1:0] smp;
  assign smp = sample[IW-1:0];
  assign dn = IW'(sample - prev);
  assign ds = IW'(sample - ENCODE_WID'(pos));
  assign sum = {1'b0, acc} + (AW+1)'(step);
  assign pos = acc[AW-1:EXTEND_WIDTH];
  // snap wraps when the shortest modular move from the current position crosses 0
  assign wrap = (WRAP_WID > 0) && (snap ? (ds < 0 ? smp > pos : smp < pos) : tick && sum[AW]);
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      delta <= ENCODE_WID'(FIRST_DELTA);
      prod <= PROD0;
      step <= acc_t'(PROD0 >>> 16);
      acc <= '0;
    end else begin
      prod <= PROD_WID'(delta) * PROD_WID'(RECIP);
      step <= acc_t'(prod >>> 16);
      if (load || snap) begin
        acc <= {smp, EXTEND_WIDTH'(0)};
        prev <= sample;
      end else if (tick) acc <= sum[AW-1:0];
      if (snap) delta <= ENCODE_WID'(dn);
    end
  end
endmodule

// File: rtl/encode_interp.sv
// encode_interp: interpolates coarse W/X encoder samples into an evenly spaced fine position stream
module encode_interp
  import encode_pkg::*;
#(
  parameter int FIRST_DELTA_WENCODE = 4,
  parameter int FIRST_DELTA_XENCODE = 512,
  parameter int UNIT_INTER = 2500,
  parameter int DELTA_UPDATE_DOT = 4,
  parameter int DELTA_UPDATE_GAP = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  encode_update_i,
  input  logic [ENCODE_WID-1:0] encode_w_i,
  input  logic [ENCODE_WID-1:0] encode_x_i,
  output logic                  wafer_zero_flag_o,
  output logic                  precise_encode_en_o,
  output logic [ENCODE_WID-1:0] precise_encode_w_o,
  output logic [ENCODE_WID-1:0] precise_encode_x_o
);
  localparam int N = UNIT_INTER * DELTA_UPDATE_DOT / DELTA_UPDATE_GAP;
  localparam logic [63:0] RECIP = calc_recip(UNIT_INTER, DELTA_UPDATE_DOT, DELTA_UPDATE_GAP, EXTEND_WIDTH);
  localparam int GW = $clog2(DELTA_UPDATE_GAP);
  localparam int TW = $clog2(N + 1);
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] tick_cnt;
  logic started, tick, load, snap, w_wrap, unused_x_wrap;
  logic [MASK-1:0] w_pos;
  assign load = encode_update_i && !started;
  assign snap = encode_update_i && started;
  // an update pulse always wins over a tick in the same cycle
  assign tick = started && !encode_update_i && gap_cnt < GW'(DELTA_UPDATE_DOT) && tick_cnt < TW'(N);
  assign precise_encode_w_o = ENCODE_WID'(w_pos);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gap_cnt <= '0;
      tick_cnt <= '0;
      started <= 1'b0;
      precise_encode_en_o <= 1'b0;
      wafer_zero_flag_o <= 1'b0;
    end else begin
      gap_cnt <= (encode_update_i || gap_cnt == GW'(DELTA_UPDATE_GAP - 1)) ? '0 : gap_cnt + 1'b1;
      tick_cnt <= encode_update_i ? '0 : tick_cnt + TW'(tick);
      started <= started || encode_update_i;
      precise_encode_en_o <= encode_update_i || tick;
      wafer_zero_flag_o <= w_wrap;
    end
  end
  encode_axis_interp #(.WRAP_WID(MASK), .FIRST_DELTA(FIRST_DELTA_WENCODE), .RECIP(RECIP)) u_w (
    .clk(clk_i), .rst(rst_i), .load(load), .snap(snap), .tick(tick),
    .sample(encode_w_i), .pos(w_pos), .wrap(w_wrap)
  );
  encode_axis_interp #(.WRAP_WID(0), .FIRST_DELTA(FIRST_DELTA_XENCODE), .RECIP(RECIP)) u_x (
    .clk(clk_i), .rst(rst_i), .load(load), .snap(snap), .tick(tick),
    .sample(encode_x_i), .pos(precise_encode_x_o), .wrap(unused_x_wrap)
  );
endmodule

// File: tb/tb_encode_interp.sv
// tb_encode_interp: directed + random stimulus against a fixed-point position model of encode_interp
module tb_encode_interp;
  localparam int N = 2000;
  localparam int GAP = 5;
  localparam int DOT = 4;
  localparam int FW = 0;
  localparam int FX = 0;
  localparam longint RECIP = ((longint'(1) << 36) + N / 2) / N;
  logic clk_i = 1'b0;
  logic rst_i, encode_update_i;
  logic [31:0] encode_w_i, encode_x_i;
  logic wafer_zero_flag_o, precise_encode_en_o;
  logic [31:0] precise_encode_w_o, precise_encode_x_o;
  int checks, errors, n_en, n_flag, n_rise;
  logic [31:0] last_x, w_r, x_r;
  bit m_started, e_en, e_flag;
  longint aw, ax;
  int k, tcnt, dw, dx;
  int hw[3], hx[3];
  logic [31:0] pw, px;

  encode_interp #(.FIRST_DELTA_WENCODE(FW), .FIRST_DELTA_XENCODE(FX)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .encode_update_i(encode_update_i),
    .encode_w_i(encode_w_i), .encode_x_i(encode_x_i),
    .wafer_zero_flag_o(wafer_zero_flag_o), .precise_encode_en_o(precise_encode_en_o),
    .precise_encode_w_o(precise_encode_w_o), .precise_encode_x_o(precise_encode_x_o)
  );

  always #4 clk_i = ~clk_i;

  function automatic longint st(input int d);
    return (longint'(d) * RECIP) >>> 16;
  endfunction

  function automatic int smod(input longint v);
    longint m;
    m = v & 64'h3FFFF;
    return int'(m >= 64'h20000 ? m - 64'h40000 : m);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit u, input logic [31:0] w, input logic [31:0] x);
    longint sw, sx, ci, ni;
    rst_i = r;
    encode_update_i = u;
    encode_w_i = w;
    encode_x_i = x;
    @(posedge clk_i);
    sw = st(hw[0]);
    sx = st(hx[0]);
    e_en = 0;
    e_flag = 0;
    if (r) begin
      m_started = 0; aw = 0; ax = 0; dw = FW; dx = FX; k = 0; tcnt = 0; pw = 0; px = 0;
      hw = '{FW, FW, FW};
      hx = '{FX, FX, FX};
    end else begin
      if (u) begin
        e_en = 1;
        if (m_started) begin
          dw = smod(longint'(w) - longint'(pw));
          dx = $signed(x - px);
          ci = aw >>> 20;
          ni = ci + smod(longint'(w[17:0]) - (ci & 64'h3FFFF));
          e_flag = (ni >>> 18) != (ci >>> 18);
          aw = ni << 20;
        end else aw = longint'(w[17:0]) << 20;
        ax = longint'($signed(x)) << 20;
        m_started = 1; pw = w; px = x; k = 0; tcnt = 0;
      end else if (m_started) begin
        k++;
        if (((k - 1) % GAP) < DOT && tcnt < N) begin
          tcnt++;
          e_en = 1;
          e_flag = ((aw + sw) >>> 38) != (aw >>> 38);
          aw += sw;
          ax += sx;
        end
      end
      hw[0] = hw[1]; hw[1] = hw[2]; hw[2] = dw;
      hx[0] = hx[1]; hx[1] = hx[2]; hx[2] = dx;
    end
    #1;
    chk("en", 32'(precise_encode_en_o), 32'(e_en));
    chk("zero_flag", 32'(wafer_zero_flag_o), 32'(e_flag));
    chk("w", precise_encode_w_o, 32'((aw >>> 20) & 64'h3FFFF));
    chk("x", precise_encode_x_o, 32'(ax >>> 20));
    if (precise_encode_en_o) n_en++;
    if (wafer_zero_flag_o) n_flag++;
    if (precise_encode_en_o && !u && $signed(precise_encode_x_o) > $signed(last_x)) n_rise++;
    last_x = precise_encode_x_o;
  endtask

  task automatic interval(input logic [31:0] w, input logic [31:0] x, input int len);
    n_flag = 0;
    n_rise = 0;
    cyc(0, 1, w, x);
    n_en = 0;
    repeat (len) cyc(0, 0, $urandom, $urandom);
  endtask

  initial begin
    checks = 0; errors = 0; n_en = 0; n_flag = 0; n_rise = 0; last_x = 0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (10) cyc(0, 0, $urandom, $urandom);
    interval(2004, 2512, 2499);
    chk("en_count_first", n_en, 2000);
    chk("w_hold_first", precise_encode_w_o, 2004);
    interval(2008, 3024, 2499);
    chk("en_count_second", n_en, 2000);
    chk("x_end_second", precise_encode_x_o, 3535);
    interval(262124, 3536, 2499);
    interval(262132, 4048, 2499);
    interval(262140, 4560, 2499);
    chk("zero_flag_once", n_flag, 1);
    interval(4, 5072, 2499);
    chk("zero_flag_none_after", n_flag, 0);
    interval(12, 1536, 2499);
    interval(16, 1024, 2499);
    chk("x_monotonic_1024", n_rise, 0);
    interval(20, 512, 2499);
    chk("x_monotonic_512", n_rise, 0);
    interval(24, 0, 2499);
    chk("x_monotonic_0", n_rise, 0);
    chk("x_cross_zero", precise_encode_x_o, 32'hFFFFFDFF);
    interval(28, 32'hFFFFFE00, 2499);
    chk("x_monotonic_neg", n_rise, 0);
    w_r = 28;
    x_r = 32'hFFFFFE00;
    interval(w_r + 3, x_r + 7, 1);
    interval(w_r + 9, x_r - 40, 2);
    for (int i = 0; i < 8; i++) begin
      w_r = w_r + 32'($urandom_range(0, 64)) - 32'd32;
      x_r = x_r + 32'($urandom_range(0, 200000)) - 32'd100000;
      interval(w_r, x_r, $urandom_range(3, 3000));
    end
    interval(w_r + 5, x_r + 300, 700);
    cyc(1, 0, $urandom, $urandom);
    chk("rst_mid_en", 32'(precise_encode_en_o), 0);
    chk("rst_mid_x", precise_encode_x_o, 0);
    chk("rst_mid_w", precise_encode_w_o, 0);
    repeat (20) cyc(0, 0, $urandom, $urandom);
    interval(100, 200, 2499);
    chk("en_count_after_rst", n_en, 2000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/encode_interp.md
Name: encode_interp

Overview:
- Interpolates slow coarse encoder samples (W = rotary, wrapping; X = linear) into a dense, evenly spaced stream of fine positions.
- Coarse samples arrive with `encode_update_i` once per UNIT_INTER clocks (50 kHz at 125 MHz).
- The block emits DELTA_UPDATE_DOT valid outputs per DELTA_UPDATE_GAP clocks (100 MS/s equivalent).
- It extrapolates with the last measured per-interval delta and snaps to the true value on each sample.

Parameters:
- FIRST_DELTA_WENCODE, 4: W delta (counts per interval) used before two samples have been seen.
- FIRST_DELTA_XENCODE, 512: X delta used before two samples have been seen.
- EXTEND_WIDTH, 20: fractional bits of the internal accumulators.
- UNIT_INTER, 2500: clocks per coarse sample interval.
- DELTA_UPDATE_DOT, 4: valid outputs per tick window.
- DELTA_UPDATE_GAP, 5: clocks per tick window.
- ENCODE_MASK_WID, 18: W encoder modulus width (W wraps at 2^18).
- ENCODE_WID, 32: width of position ports.

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- encode_update_i  in  1  one-cycle pulse; a new coarse sample is valid this cycle.
- encode_w_i  in  ENCODE_WID  coarse W; only the low ENCODE_MASK_WID bits are used.
- encode_x_i  in  ENCODE_WID  coarse X.
- wafer_zero_flag_o  out  1  one-cycle pulse when interpolated W crosses the 0 / 2^MASK boundary.
- precise_encode_en_o  out  1  output-valid strobe.
- precise_encode_w_o  out  ENCODE_WID  interpolated W, masked to MASK bits and zero-extended.
- precise_encode_x_o  out  ENCODE_WID  interpolated X.

Behaviour:
- Reset:
  - All outputs are 0 and the block is idle (no en).
  - delta_w = FIRST_DELTA_WENCODE, delta_x = FIRST_DELTA_XENCODE.
  - Step registers are loaded from the FIRST_DELTA values.
  - Reset mid-interval aborts everything immediately.
- Derived constants:
  - N = UNIT_INTER*DELTA_UPDATE_DOT/DELTA_UPDATE_GAP (ticks per interval; 2000 by default).
  - RECIP = round(2^(EXTEND_WIDTH+16)/N), a 64-bit localparam.
- Update pulse, first after reset:
  - Load accW = {w_i[MASK-1:0], 0 frac} and accX = {x_i, 0 frac}.
  - Set started.
- Update pulse, subsequent:
  - delta_w = (w_new - w_prev) mod 2^MASK, sign-extended from MASK bits.
  - delta_x = x_new - x_prev, signed ENCODE_WID.
  - Snap the accumulators to the new sample; store the sample as prev.
- Step computation:
  - step = (delta * RECIP) >>> 16, signed, a 2-stage pipeline.
  - The new step takes effect on the 3rd cycle after the pulse; ticks before that use the previous step.
- Tick generator:
  - gap_cnt runs 0..GAP-1 and is forced to 0 on each update pulse.
  - A tick occurs when started, gap_cnt < DOT, and tick_cnt < N.
  - tick_cnt clears on update and saturates at N; no extrapolation beyond N ticks, outputs hold until the next sample.
- On each tick:
  - acc += step; accW wraps modulo 2^(MASK+EXTEND_WIDTH).
  - precise_*_o = integer part of the accumulator after the add; registered, en asserted the same cycle as the outputs change.
- Snap cycle: when the update arrives, outputs take the snapped value with en = 1 in that same cycle (counts as tick 0).
- wafer_zero_flag_o:
  - Asserted with en when the W integer part wraps, either by carry out of bit MASK-1 (forward) or by borrow (reverse), including at a snap.
  - Never asserted without en.
- Widths:
  - The X accumulator is ENCODE_WID+EXTEND_WIDTH bits, two's-complement wrap, no saturation.
  - Multiplier product is ENCODE_WID+40 bits signed.
- Simultaneous update and tick: the update wins; snap, counters clear, old step applied nowhere.

Decomposition:
- Package encode_pkg holds:
  - Widths: ENCODE_WID, EXTEND_WIDTH, MASK.
  - Function calc_recip(unit, dot, gap, ext) returning the 64-bit RECIP.
  - Fixed-point typedef for accumulators.
- One natural sub-module: encode_axis_interp, instantiated twice with a WRAP_WID parameter (MASK for W, 0 = none for X).
  - Contains delta, step multiply and accumulator.
  - Returns a wrap-carry flag.
- Tick generator and zero flag live in the top level.

Test Plan:
- Reset held 2 cycles: all outputs 0 and en low until the first encode_update_i.
- FIRST_DELTA = 0, first update (w = 2004, x = 2512):
  - Outputs snap to 2004/2512.
  - en follows the pattern 4 high / 1 low.
  - Values stay constant for 2000 ticks, then hold.
- Second update (w += 4, x += 512 after 2500 clocks):
  - Outputs snap to 2008/3024.
  - Over the next interval x rises about 0.256 per tick, reaching 3535 (≥ 3535.9 floor) by tick 2000.
  - en count between pulses is exactly 2000.
- W near wrap (w_prev = 262140, w_new = 4; delta = +8):
  - Interpolated W passes 262143→0.
  - wafer_zero_flag_o pulses exactly once, coincident with en.
- Negative delta (x decreasing by 512/interval):
  - Step is negative.
  - Output decreases monotonically; no sign error at the 32-bit boundary.
- Update pulse while ticking, and reset asserted mid-interval:
  - Update: snap overrides, counters restart.
  - Reset: outputs return to 0 next cycle and en is low.
